// File: rtl/qsys_btn_pkg.sv
// Shared defaults and helpers for the button debouncer slice.
package qsys_btn_pkg;

  localparam int unsigned BTN_WIDTH        = 8;
  localparam int unsigned BTN_TICK_DIV     = 50000;
  localparam int unsigned BTN_STABLE_TICKS = 20;

  // Bits needed to hold any value 0..max_val; never less than one bit.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    int unsigned w;
    w = $clog2(max_val + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/qsys_btn_debounce_chan.sv
// One button channel: 2-flop synchronizer, stability counter, debounced level and change strobe.
module qsys_btn_debounce_chan
  import qsys_btn_pkg::*;
#(
  parameter int unsigned STABLE_TICKS = BTN_STABLE_TICKS,
  parameter logic        RESET_LEVEL  = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic tick,
  input  logic btn_in,
  output logic btn_out,
  output logic btn_change
);

  localparam int unsigned     CW   = cnt_width(STABLE_TICKS);
  localparam logic [CW-1:0]   LAST = CW'(STABLE_TICKS - 1);

  logic          s1_q, s1_d;
  logic          s2_q, s2_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          out_q, out_d;
  logic          chg_q, chg_d;

  // Next-state: any agreeing sample clears the count; a full run of mismatching ticks commits the new level.
  always_comb begin
    s1_d  = btn_in;
    s2_d  = s1_q;
    cnt_d = cnt_q;
    out_d = out_q;
    chg_d = 1'b0;
    if (s2_q == out_q) begin
      cnt_d = '0;
    end else if (tick && (cnt_q == LAST)) begin
      out_d = s2_q;
      cnt_d = '0;
      chg_d = 1'b1;
    end else if (tick) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1_q  <= RESET_LEVEL;
      s2_q  <= RESET_LEVEL;
      cnt_q <= '0;
      out_q <= RESET_LEVEL;
      chg_q <= 1'b0;
    end else begin
      s1_q  <= s1_d;
      s2_q  <= s2_d;
      cnt_q <= cnt_d;
      out_q <= out_d;
      chg_q <= chg_d;
    end
  end

  assign btn_out    = out_q;
  assign btn_change = chg_q;

endmodule

// File: rtl/qsys_btn_debounce.sv
// Multi-channel button debouncer: shared sample-tick prescaler feeding WIDTH independent channels.
module qsys_btn_debounce
  import qsys_btn_pkg::*;
#(
  parameter int unsigned      WIDTH        = BTN_WIDTH,
  parameter int unsigned      TICK_DIV     = BTN_TICK_DIV,
  parameter int unsigned      STABLE_TICKS = BTN_STABLE_TICKS,
  parameter logic [WIDTH-1:0] RESET_LEVEL  = '1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] btn_in,
  output logic [WIDTH-1:0] btn_out,
  output logic [WIDTH-1:0] btn_change
);

  localparam int unsigned   PW    = cnt_width(TICK_DIV - 1);
  localparam logic [PW-1:0] PLAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] pcnt_q, pcnt_d;
  logic          tick;

  // Prescaler: tick on the last count, then wrap to zero.
  always_comb begin
    tick   = (pcnt_q == PLAST);
    pcnt_d = tick ? '0 : pcnt_q + PW'(1);
  end

  // Prescaler register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pcnt_q <= '0;
    end else begin
      pcnt_q <= pcnt_d;
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_chan
    qsys_btn_debounce_chan #(
      .STABLE_TICKS (STABLE_TICKS),
      .RESET_LEVEL  (RESET_LEVEL[i])
    ) u_chan (
      .clk        (clk),
      .reset_n    (reset_n),
      .tick       (tick),
      .btn_in     (btn_in[i]),
      .btn_out    (btn_out[i]),
      .btn_change (btn_change[i])
    );
  end

endmodule

// File: tb/tb_qsys_btn_debounce.sv
// Scoreboard bench: stimulus queues expected strobes/levels with absolute cycle stamps, a monitor checks them.
module tb_qsys_btn_debounce;

  typedef struct {
    int         cyc;
    logic [7:0] out;
    logic [7:0] chg;
  } exp_t;

  typedef struct {
    int lo;
    int hi;
  } win_t;

  logic       clk = 1'b0;
  logic       reset_n, reset_n2;
  logic [7:0] btn_in, btn_in2;
  logic [7:0] btn_out, btn_change, btn_out2, btn_change2;

  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  bit   done = 1'b0;
  bit   final_done = 1'b0;

  exp_t level_q[$];
  exp_t strobe_q[$];
  win_t win_q[$];

  qsys_btn_debounce #(
    .WIDTH        (8),
    .TICK_DIV     (1),
    .STABLE_TICKS (3),
    .RESET_LEVEL  (8'hFF)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .btn_in     (btn_in),
    .btn_out    (btn_out),
    .btn_change (btn_change)
  );

  qsys_btn_debounce #(
    .WIDTH        (8),
    .TICK_DIV     (4),
    .STABLE_TICKS (3),
    .RESET_LEVEL  (8'hFF)
  ) dut2 (
    .clk        (clk),
    .reset_n    (reset_n2),
    .btn_in     (btn_in2),
    .btn_out    (btn_out2),
    .btn_change (btn_change2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_level(input int c, input logic [7:0] o, input logic [7:0] ch);
    exp_t e;
    e.cyc = c; e.out = o; e.chg = ch;
    level_q.push_back(e);
  endtask

  task automatic push_strobe(input int c, input logic [7:0] o, input logic [7:0] ch);
    exp_t e;
    e.cyc = c; e.out = o; e.chg = ch;
    strobe_q.push_back(e);
  endtask

  // Monitor: checks scheduled levels, every strobe, and leftover expectations at the end.
  initial begin
    exp_t e;
    win_t w;
    forever begin
      @(negedge clk);
      while (level_q.size() > 0 && level_q[0].cyc <= cyc) begin
        e = level_q.pop_front();
        tests++;
        if (e.cyc != cyc || btn_out !== e.out || btn_change !== e.chg) begin
          fails++;
          $display("FAIL level: cyc=%0d out=%h chg=%h, want cyc=%0d out=%h chg=%h",
                   cyc, btn_out, btn_change, e.cyc, e.out, e.chg);
        end
      end
      if (btn_change !== 8'h00) begin
        tests++;
        if (strobe_q.size() == 0) begin
          fails++;
          $display("FAIL strobe: unexpected at cyc=%0d out=%h chg=%h, want no strobe",
                   cyc, btn_out, btn_change);
        end else begin
          e = strobe_q.pop_front();
          if (e.cyc != cyc || btn_out !== e.out || btn_change !== e.chg) begin
            fails++;
            $display("FAIL strobe: cyc=%0d out=%h chg=%h, want cyc=%0d out=%h chg=%h",
                     cyc, btn_out, btn_change, e.cyc, e.out, e.chg);
          end
        end
      end
      if (btn_change2 !== 8'h00) begin
        tests++;
        if (win_q.size() == 0) begin
          fails++;
          $display("FAIL prescaler_strobe: unexpected at cyc=%0d out=%h chg=%h, want no strobe",
                   cyc, btn_out2, btn_change2);
        end else begin
          w = win_q.pop_front();
          if (cyc < w.lo || cyc > w.hi || btn_out2 !== 8'h7F || btn_change2 !== 8'h80) begin
            fails++;
            $display("FAIL prescaler_strobe: cyc=%0d out=%h chg=%h, want cyc in [%0d,%0d] out=7f chg=80",
                     cyc, btn_out2, btn_change2, w.lo, w.hi);
          end
        end
      end
      if (done && !final_done) begin
        tests++;
        if (strobe_q.size() != 0) begin
          fails++;
          $display("FAIL missing_strobe: %0d pending, want 0 (next cyc=%0d)", strobe_q.size(), strobe_q[0].cyc);
        end
        tests++;
        if (level_q.size() != 0) begin
          fails++;
          $display("FAIL missing_level: %0d pending, want 0", level_q.size());
        end
        tests++;
        if (win_q.size() != 0) begin
          fails++;
          $display("FAIL prescaler_missing: %0d pending, want 0", win_q.size());
        end
        final_done = 1'b1;
      end
    end
  end

  // Stimulus.
  initial begin
    int t;
    btn_in   = 8'hFF;
    btn_in2  = 8'hFF;
    reset_n  = 1'b0;
    reset_n2 = 1'b0;
    for (int c = 1; c <= 3; c++) push_level(c, 8'hFF, 8'h00);
    step(3);
    reset_n  = 1'b1;
    reset_n2 = 1'b1;
    t = cyc;
    for (int k = 1; k <= 10; k++) push_level(t + k, 8'hFF, 8'h00);
    step(10);

    // Clean press and release on bit 0.
    t = cyc;
    btn_in = 8'hFE;
    push_level(t + 4, 8'hFF, 8'h00);
    push_level(t + 5, 8'hFE, 8'h01);
    push_level(t + 6, 8'hFE, 8'h00);
    push_strobe(t + 5, 8'hFE, 8'h01);
    step(8);
    t = cyc;
    btn_in = 8'hFF;
    push_strobe(t + 5, 8'hFF, 8'h01);
    push_level(t + 6, 8'hFF, 8'h00);
    step(8);

    // Bounce on bit 2, then a steady press.
    t = cyc;
    for (int k = 1; k <= 6; k++) push_level(t + 4 * k, 8'hFF, 8'h00);
    push_level(t + 25, 8'hFB, 8'h04);
    push_strobe(t + 25, 8'hFB, 8'h04);
    for (int k = 0; k < 10; k++) begin
      btn_in[2] = k[0];
      step(2);
    end
    btn_in[2] = 1'b0;
    step(8);
    t = cyc;
    btn_in = 8'hFF;
    push_strobe(t + 5, 8'hFF, 8'h04);
    step(8);

    // Simultaneous change on bits 1 and 6.
    t = cyc;
    btn_in = 8'hBD;
    push_level(t + 4, 8'hFF, 8'h00);
    push_level(t + 5, 8'hBD, 8'h42);
    push_strobe(t + 5, 8'hBD, 8'h42);
    step(8);
    t = cyc;
    btn_in = 8'hFF;
    push_strobe(t + 5, 8'hFF, 8'h42);
    step(8);

    // Reset in the middle of a count on bit 3.
    t = cyc;
    btn_in = 8'hF7;
    push_level(t + 4, 8'hFF, 8'h00);
    push_level(t + 5, 8'hFF, 8'h00);
    push_level(t + 8, 8'hFF, 8'h00);
    push_level(t + 9, 8'hF7, 8'h08);
    push_strobe(t + 9, 8'hF7, 8'h08);
    step(3);
    reset_n = 1'b0;
    step(1);
    reset_n = 1'b1;
    step(8);
    t = cyc;
    btn_in = 8'hFF;
    push_strobe(t + 5, 8'hFF, 8'h08);
    step(8);

    // Prescaler instance: press bit 7 at a random tick phase.
    step($urandom_range(0, 3));
    t = cyc;
    btn_in2 = 8'h7F;
    win_q.push_back('{lo: t + 11, hi: t + 14});
    step(18);

    done = 1'b1;
    for (int i = 0; i < 20 && !final_done; i++) @(negedge clk);
    if (!final_done) begin
      $display("FAIL timeout: monitor final check not reached, want completion");
      $fatal(1, "monitor did not complete");
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
